sd_clock_gen: RTL and testbench

Parametrised SD bus clock generator sitting between the system clock domain and the SD pads, driving `sdio_clk` from the 100 MHz system clock. Adds runtime divider selection (low, high, custom), glitch-free frequency switching, clock stop/resume for flow control, and an initialisation burst of a fixed number of SD clock cycles. It also emits one-cycle rise/fall strobes so the command and data engines can launch and sample in the system clock domain.

---
 rtl/sd_clk_pkg.sv | 16 +
 rtl/sd_clk_burst_counter.sv | 50 +++++
 rtl/sd_clock_gen.sv | 110 +++++++++++
 tb/tb_sd_clock_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_clk_pkg.sv
// Shared encodings and default constants for the SD bus clock generator.
package sd_clk_pkg;

  typedef enum logic [1:0] {
    SD_DIV_LOW    = 2'd0,
    SD_DIV_HIGH   = 2'd1,
    SD_DIV_CUSTOM = 2'd2
  } sd_div_sel_e;

  localparam int unsigned SD_DEF_DIV_WIDTH        = 8;
  localparam int unsigned SD_DEF_LOWFREQ_DIVIDER  = 124;
  localparam int unsigned SD_DEF_HIGHFREQ_DIVIDER = 1;
  localparam int unsigned SD_DEF_BURST_CYCLES     = 80;
  localparam int unsigned SD_INIT_MIN_CYCLES      = 74;

endpackage

// File: rtl/sd_clk_burst_counter.sv
// Init-burst edge counter: counts SD clock rises down from BURST_CYCLES and
// releases the burst on the fall that follows the last rise.
module sd_clk_burst_counter
  import sd_clk_pkg::*;
#(
  parameter int unsigned BURST_CYCLES = SD_DEF_BURST_CYCLES  // keep >= SD_INIT_MIN_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_dec,
  input  logic i_fall,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned CW = $clog2(BURST_CYCLES + 1);

  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load && !r_busy) begin
        r_busy  <= 1'b1;
        r_count <= CW'(BURST_CYCLES);
      end else if (r_busy) begin
        if (i_dec && (r_count != '0)) begin
          r_count <= r_count - CW'(1);
        end
        // Rises and falls never coincide, so a zero count here means the
        // last rise has already been taken.
        if (i_fall && (r_count == '0)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/sd_clock_gen.sv
// SD bus clock generator: divided sdio_clk with glitch-free divider switching,
// stop/resume on low level only, rise/fall strobes and an init burst.
module sd_clock_gen
  import sd_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH        = SD_DEF_DIV_WIDTH,
  parameter int unsigned LOWFREQ_DIVIDER  = SD_DEF_LOWFREQ_DIVIDER,
  parameter int unsigned HIGHFREQ_DIVIDER = SD_DEF_HIGHFREQ_DIVIDER,
  parameter int unsigned BURST_CYCLES     = SD_DEF_BURST_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           div_select,
  input  logic [DIV_WIDTH-1:0] custom_div,
  input  logic                 clk_enable,
  input  logic                 burst_start,
  output logic                 sdio_clk,
  output logic                 rise_stb,
  output logic                 fall_stb,
  output logic                 clk_stopped,
  output logic                 burst_busy,
  output logic                 burst_done
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div_active;
  logic                 r_sdio_clk;
  logic                 r_rise_stb;
  logic                 r_fall_stb;
  logic                 r_stopped;

  logic [DIV_WIDTH-1:0] w_div_sel;
  logic                 w_run;
  logic                 w_half_done;
  logic                 w_stop;
  logic                 w_rise_evt;
  logic                 w_fall_evt;
  logic                 w_burst_busy;
  logic                 w_burst_done;

  always_comb begin
    w_div_sel = DIV_WIDTH'(LOWFREQ_DIVIDER);
    case (div_select)
      SD_DIV_HIGH:   w_div_sel = DIV_WIDTH'(HIGHFREQ_DIVIDER);
      SD_DIV_CUSTOM: w_div_sel = custom_div;
      default:       w_div_sel = DIV_WIDTH'(LOWFREQ_DIVIDER);
    endcase
  end

  // burst_start counts as a run request so a burst launched as clk_enable
  // falls keeps the clock going.
  assign w_run       = clk_enable | w_burst_busy | burst_start;
  assign w_half_done = (r_cnt == r_div_active);
  assign w_stop      = !r_stopped && !r_sdio_clk && !w_run;
  assign w_rise_evt  = !r_stopped && !r_sdio_clk && w_run && w_half_done;
  assign w_fall_evt  = !r_stopped && r_sdio_clk && w_half_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_div_active <= DIV_WIDTH'(LOWFREQ_DIVIDER);
      r_sdio_clk   <= 1'b0;
      r_rise_stb   <= 1'b0;
      r_fall_stb   <= 1'b0;
      r_stopped    <= 1'b1;
    end else begin
      r_rise_stb <= w_rise_evt;
      r_fall_stb <= w_fall_evt;
      if (r_stopped) begin
        r_div_active <= w_div_sel;
        r_cnt        <= '0;
        if (w_run) begin
          r_stopped <= 1'b0;
        end
      end else if (w_stop) begin
        // Only reachable in the low phase: a high phase always runs out.
        r_stopped <= 1'b1;
        r_cnt     <= '0;
      end else if (w_half_done) begin
        r_sdio_clk <= ~r_sdio_clk;
        r_cnt      <= '0;
        if (r_sdio_clk) begin
          r_div_active <= w_div_sel;
        end
      end else begin
        r_cnt <= r_cnt + DIV_WIDTH'(1);
      end
    end
  end

  sd_clk_burst_counter #(
    .BURST_CYCLES (BURST_CYCLES)
  ) u_burst_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (burst_start),
    .i_dec   (w_rise_evt),
    .i_fall  (w_fall_evt),
    .o_busy  (w_burst_busy),
    .o_done  (w_burst_done)
  );

  assign sdio_clk    = r_sdio_clk;
  assign rise_stb    = r_rise_stb;
  assign fall_stb    = r_fall_stb;
  assign clk_stopped = r_stopped;
  assign burst_busy  = w_burst_busy;
  assign burst_done  = w_burst_done;

endmodule

// File: tb/tb_sd_clock_gen.sv
// Bench for sd_clock_gen: expected strobe events (kind + cycle) are queued
// when stimulus is applied and compared as the DUT emits strobes.
module tb_sd_clock_gen;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] div_select = 2'd0;
  logic [7:0] custom_div = 8'd0;
  logic       clk_enable = 1'b0;
  logic       burst_start = 1'b0;
  logic       sdio_clk, rise_stb, fall_stb, clk_stopped, burst_busy, burst_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sd_clock_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .div_select  (div_select),
    .custom_div  (custom_div),
    .clk_enable  (clk_enable),
    .burst_start (burst_start),
    .sdio_clk    (sdio_clk),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .clk_stopped (clk_stopped),
    .burst_busy  (burst_busy),
    .burst_done  (burst_done)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] evt(input logic rise, input int t);
    return {31'd0, rise, 32'(t)};
  endfunction

  task automatic push_evt(input logic rise, input int t);
    exp_q.push_back(evt(rise, t));
  endtask

  task automatic pop_cmp(input logic rise);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("extra_stb", evt(rise, cyc), W'(0));
    end else begin
      e = exp_q.pop_front();
      check_val(rise ? "rise_evt" : "fall_evt", evt(rise, cyc), e);
    end
  endtask

  always @(negedge clk) begin
    if (rise_stb) begin
      check_val("rise_lvl", W'(sdio_clk), W'(1));
      pop_cmp(1'b1);
    end
    if (fall_stb) begin
      check_val("fall_lvl", W'(sdio_clk), W'(0));
      pop_cmp(1'b0);
    end
    if (burst_done) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_sdio"}, W'(sdio_clk), W'(0));
    check_val({tag, "_rise"}, W'(rise_stb), W'(0));
    check_val({tag, "_fall"}, W'(fall_stb), W'(0));
    check_val({tag, "_stopped"}, W'(clk_stopped), W'(1));
    check_val({tag, "_busy"}, W'(burst_busy), W'(0));
    check_val({tag, "_done"}, W'(burst_done), W'(0));
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int c, d, b, e, r;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    goto(cyc + 5);
    check_reset_vals("post_rst");

    // Low-speed run: first rise 126 cycles after enable, period 250.
    c = cyc;
    clk_enable = 1'b1;
    div_select = 2'd0;
    push_evt(1'b1, c + 126);
    push_evt(1'b0, c + 251);
    push_evt(1'b1, c + 376);
    goto(c + 1);
    check_val("resume_stopped", W'(clk_stopped), W'(0));

    // Switch to high speed mid high phase; back to low on the reload cycle.
    goto(c + 400);
    div_select = 2'd1;
    push_evt(1'b0, c + 501);
    push_evt(1'b1, c + 503);
    push_evt(1'b0, c + 505);
    push_evt(1'b1, c + 507);
    goto(c + 508);
    div_select = 2'd0;
    push_evt(1'b0, c + 509);
    push_evt(1'b1, c + 634);

    // Stop 10 cycles into a high phase: the high phase still completes.
    goto(c + 644);
    clk_enable = 1'b0;
    push_evt(1'b0, c + 759);
    goto(c + 759);
    check_val("stop_before", W'(clk_stopped), W'(0));
    goto(c + 760);
    check_val("stop_after", W'(clk_stopped), W'(1));
    check_val("stop_sdio", W'(sdio_clk), W'(0));

    // Resume, then stop from the low phase.
    goto(c + 780);
    d = cyc;
    clk_enable = 1'b1;
    push_evt(1'b1, d + 126);
    push_evt(1'b0, d + 251);
    goto(d + 260);
    check_val("low_stop_before", W'(clk_stopped), W'(0));
    clk_enable = 1'b0;
    goto(d + 261);
    check_val("low_stop_after", W'(clk_stopped), W'(1));

    // Init burst with clk_enable low: exactly 80 rises, done on the last fall.
    goto(d + 300);
    b = cyc;
    n_done = 0;
    check_val("burst_idle", W'(burst_busy), W'(0));
    burst_start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      push_evt(1'b1, b + 126 + k * 250);
      push_evt(1'b0, b + 251 + k * 250);
    end
    goto(b + 1);
    burst_start = 1'b0;
    check_val("burst_busy_set", W'(burst_busy), W'(1));
    check_val("burst_run", W'(clk_stopped), W'(0));
    goto(b + 5000);
    burst_start = 1'b1;
    goto(b + 5001);
    burst_start = 1'b0;
    goto(b + 20000);
    check_val("burst_busy_end", W'(burst_busy), W'(1));
    check_val("burst_done_early", W'(burst_done), W'(0));
    goto(b + 20001);
    check_val("burst_busy_clr", W'(burst_busy), W'(0));
    check_val("burst_done_pulse", W'(burst_done), W'(1));
    goto(b + 20002);
    check_val("burst_done_clr", W'(burst_done), W'(0));
    check_val("burst_stopped", W'(clk_stopped), W'(1));
    check_val("burst_done_count", W'(n_done), W'(1));

    // Custom divider 0: toggle every cycle.
    goto(b + 20050);
    e = cyc;
    div_select = 2'd2;
    custom_div = 8'd0;
    clk_enable = 1'b1;
    for (int j = 0; j < 5; j++) begin
      push_evt(1'b1, e + 2 + 2 * j);
      push_evt(1'b0, e + 3 + 2 * j);
    end
    goto(e + 11);
    clk_enable = 1'b0;
    goto(e + 12);
    check_val("div0_stopped", W'(clk_stopped), W'(1));
    check_val("div0_sdio", W'(sdio_clk), W'(0));

    // Async reset mid-burst during a high phase; release must be silent.
    goto(e + 30);
    r = cyc;
    div_select = 2'd0;
    burst_start = 1'b1;
    push_evt(1'b1, r + 126);
    goto(r + 1);
    burst_start = 1'b0;
    goto(r + 130);
    check_val("pre_rst_sdio", W'(sdio_clk), W'(1));
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    goto(r + 133);
    reset_n = 1'b1;
    goto(r + 433);
    check_reset_vals("rst_release");

    check_val("q_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
